// File: rtl/alu_sweep_driver_if.sv
// Purpose: bundles the ALU operand/response bus and the result stream of alu_sweep_driver.
//   master : driver side (drives alu_* operands and res_* stream, receives ALU response and res_ready)
//   slave  : ALU + result consumer side
// Signals:
//   alu_a, alu_b, alu_sel, alu_carry_in, alu_sign : operands to the ALU
//   alu_out, alu_zero, alu_overflow               : combinational ALU response
//   res_valid, res_ready                          : result stream handshake
//   res_data, res_sel, res_sign, res_zero, res_ovf: result FIFO head fields
//   res_count                                     : result FIFO occupancy
interface alu_sweep_driver_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SEL_W      = 4,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [SEL_W-1:0]  alu_sel;
    logic              alu_carry_in;
    logic              alu_sign;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zero;
    logic              alu_overflow;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [SEL_W-1:0]  res_sel;
    logic              res_sign;
    logic              res_zero;
    logic              res_ovf;
    logic [CNT_W-1:0]  res_count;

    modport master (
        output alu_a, alu_b, alu_sel, alu_carry_in, alu_sign,
        input  alu_out, alu_zero, alu_overflow,
        output res_valid, res_data, res_sel, res_sign, res_zero, res_ovf, res_count,
        input  res_ready
    );

    modport slave (
        input  alu_a, alu_b, alu_sel, alu_carry_in, alu_sign,
        output alu_out, alu_zero, alu_overflow,
        input  res_valid, res_data, res_sel, res_sign, res_zero, res_ovf, res_count,
        output res_ready
    );
endinterface

// File: rtl/alu_sweep_driver.sv
// Purpose: ALU operand sequencer. On start it latches operands, steps ALU_Sel from
//   sel_first to sel_last (modulo 2**SEL_W), optionally repeating with Sign=1, and
//   captures every ALU response into a show-ahead result FIFO drained by valid/ready.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   start                 : begin sweep (sampled only in IDLE)
//   op_a, op_b            : operands, latched on accepted start
//   sel_first, sel_last   : ALU_Sel range, latched on accepted start
//   both_signs, carry_in  : sweep Sign=0 then 1 / CarryIn, latched on accepted start
//   busy, done            : sweep in progress / one-cycle completion pulse
//   bus                   : ALU operand bus and result stream (master side)
module alu_sweep_driver #(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned SEL_W         = 4,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [DATA_W-1:0]   op_a,
    input  logic [DATA_W-1:0]   op_b,
    input  logic [SEL_W-1:0]    sel_first,
    input  logic [SEL_W-1:0]    sel_last,
    input  logic                both_signs,
    input  logic                carry_in,
    output logic                busy,
    output logic                done,
    alu_sweep_driver_if.master  bus
);
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = AW + 1;
    localparam int unsigned SCNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_DONE} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  sel;
        logic              sign;
        logic              zero;
        logic              ovf;
    } res_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_load;
    logic               w_push;
    logic               w_adv_sel;
    logic               w_restart_sign;
    logic               w_pop;
    logic               w_push_ok;

    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic [SEL_W-1:0]   r_sel_first;
    logic [SEL_W-1:0]   r_sel_last;
    logic               r_both;
    logic               r_carry;
    logic [SEL_W-1:0]   r_alu_sel;
    logic               r_alu_sign;
    logic [SCNT_W-1:0]  r_scnt;
    logic               r_busy;
    logic               r_done;

    res_t               r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [CNT_W-1:0]   r_count;

    // A full FIFO still accepts a push when its head leaves on the same edge.
    assign w_pop     = (r_count != '0) && bus.res_ready;
    assign w_push_ok = (r_count != CNT_W'(FIFO_DEPTH)) || w_pop;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state and datapath controls
    always_comb begin
        w_next_state   = r_state;
        w_load         = 1'b0;
        w_push         = 1'b0;
        w_adv_sel      = 1'b0;
        w_restart_sign = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_scnt == SCNT_W'(SETTLE_CYCLES - 1)) begin
                    w_next_state = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (w_push_ok) begin
                    w_push = 1'b1;
                    if (r_alu_sel != r_sel_last) begin
                        w_adv_sel    = 1'b1;
                        w_next_state = S_SETTLE;
                    end else if (r_both && !r_alu_sign) begin
                        w_restart_sign = 1'b1;
                        w_next_state   = S_SETTLE;
                    end else begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Latched sweep configuration, ALU drive registers, status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_sel_first <= '0;
            r_sel_last  <= '0;
            r_both      <= 1'b0;
            r_carry     <= 1'b0;
            r_alu_sel   <= '0;
            r_alu_sign  <= 1'b0;
            r_scnt      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_busy <= (w_next_state != S_IDLE);
            r_done <= (w_next_state == S_DONE);
            // Counter runs only while settling, so it is zero on every SETTLE entry.
            r_scnt <= (r_state == S_SETTLE) ? r_scnt + SCNT_W'(1) : '0;
            if (w_load) begin
                r_a         <= op_a;
                r_b         <= op_b;
                r_sel_first <= sel_first;
                r_sel_last  <= sel_last;
                r_both      <= both_signs;
                r_carry     <= carry_in;
                r_alu_sel   <= sel_first;
                r_alu_sign  <= 1'b0;
            end else if (w_adv_sel) begin
                r_alu_sel <= r_alu_sel + SEL_W'(1);
            end else if (w_restart_sign) begin
                r_alu_sel  <= r_sel_first;
                r_alu_sign <= 1'b1;
            end
        end
    end

    // Show-ahead result FIFO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= '{data: bus.alu_out, sel: r_alu_sel, sign: r_alu_sign,
                                   zero: bus.alu_zero, ovf: bus.alu_overflow};
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign busy             = r_busy;
    assign done             = r_done;
    assign bus.alu_a        = r_a;
    assign bus.alu_b        = r_b;
    assign bus.alu_sel      = r_alu_sel;
    assign bus.alu_sign     = r_alu_sign;
    assign bus.alu_carry_in = r_carry;
    assign bus.res_valid    = (r_count != '0);
    assign bus.res_count    = r_count;
    assign bus.res_data     = r_mem[r_rptr].data;
    assign bus.res_sel      = r_mem[r_rptr].sel;
    assign bus.res_sign     = r_mem[r_rptr].sign;
    assign bus.res_zero     = r_mem[r_rptr].zero;
    assign bus.res_ovf      = r_mem[r_rptr].ovf;
endmodule
